// File: rtl/core_ptw.sv
// Sv32 hardware page table walker for the core's caches.
// Walks up to two levels over armleobus and returns PPN, leaf bits and fault status.
module core_ptw (
    input  logic        clk,
    input  logic        rst,
    input  logic        resolve_request,
    input  logic [19:0] resolve_virtual_address,
    input  logic [21:0] satp_ppn,
    output logic        resolve_ack,
    output logic        resolve_done,
    output logic        resolve_pagefault,
    output logic        resolve_accessfault,
    output logic [21:0] resolve_physical_address,
    output logic [7:0]  resolve_metadata,
    output logic        m_transaction,
    output logic [1:0]  m_cmd,
    output logic [33:0] m_address,
    input  logic        m_transaction_done,
    input  logic [1:0]  m_transaction_response,
    input  logic [31:0] m_rdata
);

    localparam logic [1:0] CMD_READ = 2'b01;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        TABLE_ACCESS,
        DONE
    } state_t;

    state_t      state;
    logic        level;
    logic [19:0] vpn;
    logic [21:0] table_ppn;

    logic pte_v;
    logic pte_r;
    logic pte_w;
    logic pte_x;
    logic pte_invalid;
    logic pte_leaf;
    logic mega_misaligned;
    logic unused_rsw;

    assign pte_v = m_rdata[0];
    assign pte_r = m_rdata[1];
    assign pte_w = m_rdata[2];
    assign pte_x = m_rdata[3];
    assign pte_invalid = !pte_v || (!pte_r && pte_w);
    assign pte_leaf = pte_r || pte_x;
    assign mega_misaligned = (m_rdata[19:10] != 10'd0);
    assign unused_rsw = ^m_rdata[9:8];

    // Request handshake is combinational so the cache sees acceptance in-cycle.
    assign resolve_ack = (state == IDLE) && resolve_request && !rst;

    assign m_cmd = CMD_READ;

    // Table base is satp at level 1 and the pointer PTE's PPN at level 0.
    assign m_address = {table_ppn, (level ? vpn[19:10] : vpn[9:0]), 2'b00};

    // Walk FSM with registered bus request and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                    <= IDLE;
            level                    <= 1'b1;
            vpn                      <= 20'd0;
            table_ppn                <= 22'd0;
            m_transaction            <= 1'b0;
            resolve_done             <= 1'b0;
            resolve_pagefault        <= 1'b0;
            resolve_accessfault      <= 1'b0;
            resolve_physical_address <= 22'd0;
            resolve_metadata         <= 8'd0;
        end else begin
            resolve_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (resolve_request) begin
                        vpn           <= resolve_virtual_address;
                        table_ppn     <= satp_ppn;
                        level         <= 1'b1;
                        m_transaction <= 1'b1;
                        state         <= TABLE_ACCESS;
                    end
                end
                TABLE_ACCESS: begin
                    if (m_transaction_done) begin
                        if (m_transaction_response != RESP_OKAY) begin
                            resolve_accessfault <= 1'b1;
                            resolve_pagefault   <= 1'b0;
                            m_transaction       <= 1'b0;
                            resolve_done        <= 1'b1;
                            state               <= DONE;
                        end else if (pte_invalid
                                     || (pte_leaf && level && mega_misaligned)
                                     || (!pte_leaf && !level)) begin
                            resolve_pagefault   <= 1'b1;
                            resolve_accessfault <= 1'b0;
                            m_transaction       <= 1'b0;
                            resolve_done        <= 1'b1;
                            state               <= DONE;
                        end else if (pte_leaf) begin
                            resolve_pagefault   <= 1'b0;
                            resolve_accessfault <= 1'b0;
                            resolve_metadata    <= m_rdata[7:0];
                            if (level) begin
                                resolve_physical_address <=
                                    {m_rdata[31:20], vpn[9:0]};
                            end else begin
                                resolve_physical_address <= m_rdata[31:10];
                            end
                            m_transaction <= 1'b0;
                            resolve_done  <= 1'b1;
                            state         <= DONE;
                        end else begin
                            table_ppn <= m_rdata[31:10];
                            level     <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    level <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
